// File: rtl/vx_tcu_csr_bank_pkg.sv
// Package for the tensor-core CSR bank.
// Holds the default CSR file geometry, the status register layout and the
// address decode helper shared by the decoder instances.
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif

package VX_tcu_pkg;

    localparam int NUM_TCU_CSRS = 8;
    localparam logic [`VX_CSR_ADDR_BITS-1:0] TCU_CSR_BASE = `VX_CSR_ADDR_BITS'('hBC0);

    typedef struct packed {
        logic [15:0] dirty;
        logic [15:0] write_cnt;
    } tcu_csr_status_t;

    typedef struct packed {
        logic       hit;
        logic       is_status;
        logic [3:0] idx;
    } tcu_csr_dec_t;

    // Address arithmetic is done at 32 bits so the same helper serves any
    // CSR address width up to 32. The status register sits just past the file.
    function automatic tcu_csr_dec_t tcu_csr_decode(
        input logic [31:0] addr,
        input logic [31:0] base = 32'(TCU_CSR_BASE),
        input logic [31:0] num  = 32'(NUM_TCU_CSRS)
    );
        tcu_csr_dec_t d;
        logic [31:0]  off;
        off         = addr - base;
        d.hit       = (addr >= base) && (off < num);
        d.is_status = (addr >= base) && (off == num);
        d.idx       = 4'(off & (num - 32'd1));
        return d;
    endfunction

endpackage

// File: rtl/vx_tcu_csr_bank_decode.sv
// Combinational CSR address decoder for the tensor-core CSR bank.
// Ports:
//   addr      in  ADDR_BITS  CSR address to decode
//   hit       out 1          address falls inside the register file
//   is_status out 1          address is the status register
//   idx       out IDX_W      register index within the file
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif

module VX_tcu_csr_decode
    import VX_tcu_pkg::*;
#(
    parameter int                    NUM_REGS  = NUM_TCU_CSRS,
    parameter int                    ADDR_BITS = `VX_CSR_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0]  BASE_ADDR = ADDR_BITS'(TCU_CSR_BASE),
    localparam int                   IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 hit,
    output logic                 is_status,
    output logic [IDX_W-1:0]     idx
);

    tcu_csr_dec_t dec;

    assign dec       = tcu_csr_decode(32'(addr), 32'(BASE_ADDR), 32'(NUM_REGS));
    assign hit       = dec.hit;
    assign is_status = dec.is_status;
    assign idx       = dec.idx[IDX_W-1:0];

    // Upper index bits are zero whenever the file is smaller than 16 entries.
    logic unused_idx_bits;
    assign unused_idx_bits = ^dec.idx;

endmodule

// File: rtl/vx_tcu_csr_bank.sv
// Tensor-core CSR bank: CSR-side slave of the tensor-core/CSR link.
// Owns the tensor CSR file, serves TCU paired reads (a = reg[i], b = reg[i+1]
// with wrap), TCU writes, and core CSR-unit reads/writes. A read-to-clear
// status register reports a dirty mask and a saturating TCU write count.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   tcu_write_enable/addr/data        TCU write, always accepted
//   tcu_write_err                     pulse: previous TCU write dropped (miss)
//   tcu_read_enable/addr              TCU paired read request
//   tcu_read_data_a/b, tcu_read_valid registered read result, data held between reads
//   core_req_valid/ready/write/addr/data  core CSR request (valid/ready)
//   core_rsp_valid/data/err           registered core response, 1 cycle after accept
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif

module vx_tcu_csr_bank
    import VX_tcu_pkg::*;
#(
    parameter int                   NUM_REGS  = NUM_TCU_CSRS,
    parameter int                   ADDR_BITS = `VX_CSR_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = ADDR_BITS'(TCU_CSR_BASE)
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 tcu_write_enable,
    input  logic [ADDR_BITS-1:0] tcu_write_addr,
    input  logic [31:0]          tcu_write_data,
    output logic                 tcu_write_err,

    input  logic                 tcu_read_enable,
    input  logic [ADDR_BITS-1:0] tcu_read_addr,
    output logic [31:0]          tcu_read_data_a,
    output logic [31:0]          tcu_read_data_b,
    output logic                 tcu_read_valid,

    input  logic                 core_req_valid,
    output logic                 core_req_ready,
    input  logic                 core_req_write,
    input  logic [ADDR_BITS-1:0] core_req_addr,
    input  logic [31:0]          core_req_data,
    output logic                 core_rsp_valid,
    output logic [31:0]          core_rsp_data,
    output logic                 core_rsp_err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [31:0] regs [NUM_REGS];
    tcu_csr_status_t status_q, status_next;

    logic             tw_hit, tr_hit, core_hit, core_is_status;
    logic             tw_status_unused, tr_status_unused;
    logic [IDX_W-1:0] tw_idx, tr_idx, tr_idx_b, core_idx;

    VX_tcu_csr_decode #(.NUM_REGS(NUM_REGS), .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE_ADDR)) tw_dec (
        .addr      (tcu_write_addr),
        .hit       (tw_hit),
        .is_status (tw_status_unused),
        .idx       (tw_idx)
    );

    VX_tcu_csr_decode #(.NUM_REGS(NUM_REGS), .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE_ADDR)) tr_dec (
        .addr      (tcu_read_addr),
        .hit       (tr_hit),
        .is_status (tr_status_unused),
        .idx       (tr_idx)
    );

    VX_tcu_csr_decode #(.NUM_REGS(NUM_REGS), .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE_ADDR)) core_dec (
        .addr      (core_req_addr),
        .hit       (core_hit),
        .is_status (core_is_status),
        .idx       (core_idx)
    );

    // Power-of-two file size makes the natural index overflow the wrap to reg[0].
    assign tr_idx_b = tr_idx + 1'b1;

    // The TCU always wins a write collision; core reads never stall.
    assign core_req_ready = ~(core_req_write & tcu_write_enable);

    logic core_fire, tcu_wr_ok, core_wr_ok, status_rd;
    assign core_fire  = core_req_valid & core_req_ready;
    assign tcu_wr_ok  = tcu_write_enable & tw_hit;
    assign core_wr_ok = core_fire & core_req_write & core_hit;
    assign status_rd  = core_fire & ~core_req_write & core_is_status;

    // A status read clears first; a TCU write in the same cycle then lands on
    // the cleared value so its dirty bit and count survive.
    always_comb begin
        status_next = status_q;
        if (status_rd) begin
            status_next = '0;
        end
        if (tcu_wr_ok) begin
            status_next.dirty = status_next.dirty | (16'd1 << tw_idx);
            if (status_next.write_cnt != 16'hFFFF) begin
                status_next.write_cnt = status_next.write_cnt + 16'd1;
            end
        end
    end

    logic [31:0] core_rd_data;
    logic        core_err;

    always_comb begin
        core_rd_data = '0;
        if (core_fire && !core_req_write) begin
            if (core_hit) begin
                core_rd_data = regs[core_idx];
            end else if (core_is_status) begin
                core_rd_data = status_q;
            end
        end
        core_err = core_fire & ~(core_hit | (core_is_status & ~core_req_write));
    end

    // ---- state commit / registered outputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            status_q <= '0;
        end else begin
            if (tcu_wr_ok) begin
                regs[tw_idx] <= tcu_write_data;
            end else if (core_wr_ok) begin
                regs[core_idx] <= core_req_data;
            end
            status_q <= status_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcu_read_valid  <= 1'b0;
            tcu_read_data_a <= '0;
            tcu_read_data_b <= '0;
            tcu_write_err   <= 1'b0;
            core_rsp_valid  <= 1'b0;
            core_rsp_data   <= '0;
            core_rsp_err    <= 1'b0;
        end else begin
            tcu_read_valid <= tcu_read_enable;
            if (tcu_read_enable) begin
                tcu_read_data_a <= tr_hit ? regs[tr_idx]   : 32'd0;
                tcu_read_data_b <= tr_hit ? regs[tr_idx_b] : 32'd0;
            end
            tcu_write_err  <= tcu_write_enable & ~tw_hit;
            core_rsp_valid <= core_fire;
            core_rsp_data  <= core_rd_data;
            core_rsp_err   <= core_err;
        end
    end

endmodule

// File: tb/tb_vx_tcu_csr_bank.sv
module tb_vx_tcu_csr_bank;

    localparam int          N    = 8;
    localparam logic [11:0] BASE = 12'hBC0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tcu_write_enable = 1'b0;
    logic [11:0] tcu_write_addr = '0;
    logic [31:0] tcu_write_data = '0;
    logic        tcu_write_err;
    logic        tcu_read_enable = 1'b0;
    logic [11:0] tcu_read_addr = '0;
    logic [31:0] tcu_read_data_a, tcu_read_data_b;
    logic        tcu_read_valid;
    logic        core_req_valid = 1'b0;
    logic        core_req_ready;
    logic        core_req_write = 1'b0;
    logic [11:0] core_req_addr = '0;
    logic [31:0] core_req_data = '0;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic        core_rsp_err;

    vx_tcu_csr_bank dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tcu_write_enable (tcu_write_enable),
        .tcu_write_addr   (tcu_write_addr),
        .tcu_write_data   (tcu_write_data),
        .tcu_write_err    (tcu_write_err),
        .tcu_read_enable  (tcu_read_enable),
        .tcu_read_addr    (tcu_read_addr),
        .tcu_read_data_a  (tcu_read_data_a),
        .tcu_read_data_b  (tcu_read_data_b),
        .tcu_read_valid   (tcu_read_valid),
        .core_req_valid   (core_req_valid),
        .core_req_ready   (core_req_ready),
        .core_req_write   (core_req_write),
        .core_req_addr    (core_req_addr),
        .core_req_data    (core_req_data),
        .core_rsp_valid   (core_rsp_valid),
        .core_rsp_data    (core_rsp_data),
        .core_rsp_err     (core_rsp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_regs [N];
    logic [15:0] m_dirty;
    logic [15:0] m_cnt;
    logic [31:0] e_a, e_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rel(input logic [11:0] a);
        return int'(a) - int'(BASE);
    endfunction

    function automatic bit in_file(input int r);
        return (r >= 0) && (r < N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_dirty = '0;
        m_cnt   = '0;
        e_a     = '0;
        e_b     = '0;
    endtask

    task automatic drive(input bit tw, input logic [11:0] twa, input logic [31:0] twd,
                         input bit tr, input logic [11:0] tra,
                         input bit cv, input bit cw, input logic [11:0] ca, input logic [31:0] cd);
        tcu_write_enable = tw;
        tcu_write_addr   = twa;
        tcu_write_data   = twd;
        tcu_read_enable  = tr;
        tcu_read_addr    = tra;
        core_req_valid   = cv;
        core_req_write   = cw;
        core_req_addr    = ca;
        core_req_data    = cd;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, '0, 0, 0, '0, '0);
    endtask

    // Applies the currently driven inputs for one clock and checks the outputs
    // against the model's prediction.
    task automatic cycle();
        int          tw, tr, cr;
        bit          fire, e_rv, e_werr, e_cv, e_cerr;
        logic [31:0] e_cd;
        #1;
        tw   = rel(tcu_write_addr);
        tr   = rel(tcu_read_addr);
        cr   = rel(core_req_addr);
        fire = core_req_valid && !(core_req_write && tcu_write_enable);
        check("core_req_ready", 32'(core_req_ready), 32'(!(core_req_write && tcu_write_enable)));

        e_rv = tcu_read_enable;
        if (tcu_read_enable) begin
            e_a = in_file(tr) ? m_regs[tr] : 32'd0;
            e_b = in_file(tr) ? m_regs[(tr + 1) % N] : 32'd0;
        end
        e_werr = tcu_write_enable && !in_file(tw);
        e_cv   = fire;
        e_cd   = '0;
        e_cerr = 1'b0;
        if (fire) begin
            if (!core_req_write && in_file(cr))  e_cd = m_regs[cr];
            else if (!core_req_write && cr == N) e_cd = {m_dirty, m_cnt};
            e_cerr = !(in_file(cr) || (cr == N && !core_req_write));
        end

        if (fire && !core_req_write && cr == N) begin
            m_dirty = '0;
            m_cnt   = '0;
        end
        if (tcu_write_enable && in_file(tw)) begin
            m_regs[tw] = tcu_write_data;
            m_dirty    = m_dirty | (16'd1 << tw);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (fire && core_req_write && in_file(cr)) m_regs[cr] = core_req_data;

        @(posedge clk);
        #1;
        check("tcu_read_valid", 32'(tcu_read_valid), 32'(e_rv));
        check("tcu_read_data_a", tcu_read_data_a, e_a);
        check("tcu_read_data_b", tcu_read_data_b, e_b);
        check("tcu_write_err", 32'(tcu_write_err), 32'(e_werr));
        check("core_rsp_valid", 32'(core_rsp_valid), 32'(e_cv));
        if (e_cv) begin
            check("core_rsp_data", core_rsp_data, e_cd);
            check("core_rsp_err", 32'(core_rsp_err), 32'(e_cerr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(tcu_read_valid), 32'd0);
        check({tag, "_a"}, tcu_read_data_a, 32'd0);
        check({tag, "_b"}, tcu_read_data_b, 32'd0);
        check({tag, "_werr"}, 32'(tcu_write_err), 32'd0);
        check({tag, "_rsp_valid"}, 32'(core_rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, core_rsp_data, 32'd0);
        check({tag, "_rsp_err"}, 32'(core_rsp_err), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Populate a little state, then reset in the middle of traffic.
        drive(1, BASE + 12'd1, 32'h1111_0001, 1, BASE, 1, 0, BASE + 12'd8, '0); cycle();
        drive(1, BASE + 12'd2, 32'h2222_0002, 1, BASE + 12'd1, 1, 0, BASE + 12'd1, '0); cycle();
        drive(1, BASE + 12'd3, 32'h3333_0003, 1, BASE + 12'd2, 1, 0, BASE + 12'd2, '0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid");
        model_reset();
        idle();
        reset_n = 1'b1;
        drive(0, '0, '0, 1, BASE, 0, 0, '0, '0); cycle();
        check("post_reset_read_valid", 32'(tcu_read_valid), 32'd1);
        check("post_reset_read_a", tcu_read_data_a, 32'd0);

        // Write then paired read; wrap of b at the top index.
        drive(1, BASE + 12'd3, 32'hDEADBEEF, 0, '0, 0, 0, '0, '0); cycle();
        drive(0, '0, '0, 1, BASE + 12'd2, 0, 0, '0, '0); cycle();
        check("paired_read_b", tcu_read_data_b, 32'hDEADBEEF);
        drive(1, BASE, 32'hA5A5_0000, 0, '0, 0, 0, '0, '0); cycle();
        drive(0, '0, '0, 1, BASE + 12'd7, 0, 0, '0, '0); cycle();
        check("wrap_read_b", tcu_read_data_b, 32'hA5A5_0000);
        // Same-cycle write is not visible to a read.
        drive(1, BASE + 12'd5, 32'h5555_5555, 1, BASE + 12'd5, 0, 0, '0, '0); cycle();
        check("same_cycle_read_a", tcu_read_data_a, 32'd0);

        // Collision: TCU write stalls core write; core retries.
        drive(1, BASE + 12'd6, 32'h6666_6666, 0, '0, 1, 1, BASE + 12'd4, 32'hC0DE_0004);
        #1 check("collision_ready", 32'(core_req_ready), 32'd0);
        cycle();
        drive(0, '0, '0, 0, '0, 1, 1, BASE + 12'd4, 32'hC0DE_0004); cycle();
        check("retry_rsp_valid", 32'(core_rsp_valid), 32'd1);
        drive(0, '0, '0, 0, '0, 1, 0, BASE + 12'd4, '0); cycle();
        check("retry_committed", core_rsp_data, 32'hC0DE_0004);

        // Clear status, then three TCU writes to idx 1, 1, 4.
        drive(0, '0, '0, 0, '0, 1, 0, BASE + 12'd8, '0); cycle();
        drive(1, BASE + 12'd1, 32'd11, 0, '0, 0, 0, '0, '0); cycle();
        drive(1, BASE + 12'd1, 32'd12, 0, '0, 0, 0, '0, '0); cycle();
        drive(1, BASE + 12'd4, 32'd14, 0, '0, 0, 0, '0, '0); cycle();
        drive(0, '0, '0, 0, '0, 1, 0, BASE + 12'd8, '0); cycle();
        check("status_first", core_rsp_data, 32'h0012_0003);
        drive(0, '0, '0, 0, '0, 1, 0, BASE + 12'd8, '0); cycle();
        check("status_second", core_rsp_data, 32'h0000_0000);

        // Status read racing a TCU write to idx 2.
        drive(1, BASE + 12'd7, 32'd77, 0, '0, 0, 0, '0, '0); cycle();
        drive(1, BASE + 12'd2, 32'd22, 0, '0, 1, 0, BASE + 12'd8, '0); cycle();
        check("status_race_old", core_rsp_data, 32'h0080_0001);
        drive(0, '0, '0, 0, '0, 1, 0, BASE + 12'd8, '0); cycle();
        check("status_race_after", core_rsp_data, 32'h0004_0001);

        // Out-of-range accesses.
        drive(1, BASE + 12'd9, 32'hBAD0_0009, 0, '0, 0, 0, '0, '0); cycle();
        check("miss_write_err", 32'(tcu_write_err), 32'd1);
        drive(1, BASE + 12'd8, 32'hBAD0_0008, 0, '0, 1, 1, BASE + 12'd8, 32'd1); cycle();
        drive(0, '0, '0, 0, '0, 1, 1, BASE + 12'd8, 32'd1); cycle();
        check("status_write_err", 32'(core_rsp_err), 32'd1);
        drive(0, '0, '0, 0, '0, 1, 0, BASE - 12'd1, '0); cycle();
        check("core_miss_err", 32'(core_rsp_err), 32'd1);
        check("core_miss_data", core_rsp_data, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 1), BASE - 12'd2 + 12'($urandom_range(0, 12)), $urandom,
                  $urandom_range(0, 1), BASE - 12'd2 + 12'($urandom_range(0, 12)),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? BASE + 12'd8 : BASE - 12'd2 + 12'($urandom_range(0, 12)),
                  $urandom);
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
